// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with a fixed number of wait states, a side-band preload port
// and a sticky flag for accesses outside the mapped window.
module avalon_wait_ram #(
    parameter int          DEPTH_LOG2  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [3:0]            byteenable,
    input  logic [31:0]           writedata,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  range_err
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  req;
    logic                  complete;
    logic                  enter_ack;

    // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned compare covers both ends.
    assign offset    = address - BASE_ADDR;
    assign in_range  = offset < SPAN;
    assign word_idx  = offset[DEPTH_LOG2+1:2];
    assign req       = read | write;
    assign complete  = (state_q == ACK) && req;
    assign enter_ack = (state_d == ACK) && (state_q != ACK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                if (!req)             state_d = IDLE;
                else if (cnt_q == '0) state_d = ACK;
                else                  cnt_d   = cnt_q - 4'd1;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Held low during reset so a master never sees a stall from a block that is not running.
    assign waitrequest = reset && req && (state_q != ACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            readdata  <= '0;
            range_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_ack && read && !write)
                readdata <= in_range ? mem[word_idx] : 32'h0;
            if (complete && !in_range)
                range_err <= 1'b1;
        end
    end

    // Array has no reset; preload is applied last so it overrides a colliding bus write.
    always_ff @(posedge clk) begin
        if (complete && write && in_range) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[word_idx][8*b +: 8] <= writedata[8*b +: 8];
        end
        if (load_en)
            mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Bench for avalon_wait_ram: one instance with 2 wait states, one with none, sharing bus
// and preload signals; sel routes read/write to one of them.
module tb_avalon_wait_ram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic [31:0] address, writedata, load_data;
    logic        read, write, load_en;
    logic [3:0]  byteenable;
    logic [7:0]  load_addr;
    logic        rd_en_a, wr_en_a, rd_en_b, wr_en_b;
    logic        wq_a, wq_b, re_a, re_b;
    logic [31:0] rd_a, rd_b;
    logic        waitreq, rerr;
    logic [31:0] rdata;

    assign rd_en_a = read & ~sel;
    assign wr_en_a = write & ~sel;
    assign rd_en_b = read & sel;
    assign wr_en_b = write & sel;
    assign waitreq = sel ? wq_b : wq_a;
    assign rdata   = sel ? rd_b : rd_a;
    assign rerr    = sel ? re_b : re_a;

    avalon_wait_ram #(.DEPTH_LOG2(8), .BASE_ADDR(32'hBFC00000), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst_n), .address(address), .read(rd_en_a), .write(wr_en_a),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wq_a), .readdata(rd_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .range_err(re_a));

    avalon_wait_ram #(.DEPTH_LOG2(8), .BASE_ADDR(32'hBFC00000), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_n), .address(address), .read(rd_en_b), .write(wr_en_b),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(wq_b), .readdata(rd_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .range_err(re_b));

    int total = 0;
    int bad   = 0;

    logic [31:0] model [2][256];
    bit          model_rerr [2];

    typedef struct {
        bit          s;
        bit          wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          chk_rd;
        bit          exp_re;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'hBFC00000;
        return off < 32'h400;
    endfunction

    function automatic logic [7:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'hBFC00000;
        return off[9:2];
    endfunction

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Called just after a rising edge; returns with the transfer finished, just after the next edge.
    task automatic bus_xfer(input bit s, input bit wr, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, input bit pl, input logic [7:0] pa,
                            input logic [31:0] pd, output logic [31:0] rd, output int st,
                            output logic re);
        bit done;
        sel = s; address = a; byteenable = be; writedata = d;
        read = ~wr; write = wr;
        st = 0; rd = 'x; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!waitreq) begin
                done = 1;
                rd = rdata;
            end else begin
                st++;
            end
        end
        check("handshake_timeout", 32'(done), 32'd1);
        if (pl) begin
            load_en = 1'b1; load_addr = pa; load_data = pd;
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; load_en = 1'b0;
        re = rerr;
    endtask

    initial begin
        logic [31:0] rd, d, a, exp_rd;
        logic        re;
        int          st;
        bit          s, wr, pl, inr;
        logic [3:0]  be;
        logic [7:0]  w, pa;
        logic [31:0] pd;

        tbl[0]  = '{0, 0, 32'hBFC00000, 4'hF, 32'h0,        32'h24040020, 1, 0};
        tbl[1]  = '{0, 1, 32'hBFC00008, 4'h5, 32'hAABBCCDD, 32'h0,        0, 0};
        tbl[2]  = '{0, 0, 32'hBFC00008, 4'hF, 32'h0,        32'h11BB33DD, 1, 0};
        tbl[3]  = '{1, 0, 32'hBFC00004, 4'hF, 32'h0,        32'hCAFE0001, 1, 0};
        tbl[4]  = '{1, 0, 32'hBFC00008, 4'hF, 32'h0,        32'h11223344, 1, 0};
        tbl[5]  = '{0, 0, 32'h00000000, 4'hF, 32'h0,        32'h0,        1, 1};
        tbl[6]  = '{0, 1, 32'hBFC00010, 4'hF, 32'h5A5A5A5A, 32'h0,        0, 1};
        tbl[7]  = '{0, 0, 32'hBFC00010, 4'hF, 32'h0,        32'h5A5A5A5A, 1, 1};
        tbl[8]  = '{0, 1, 32'hBFC003FC, 4'hF, 32'h12345678, 32'h0,        0, 1};
        tbl[9]  = '{0, 0, 32'hBFC003FC, 4'hF, 32'h0,        32'h12345678, 1, 1};
        tbl[10] = '{0, 1, 32'hBFC00400, 4'hF, 32'hFFFFFFFF, 32'h0,        0, 1};
        tbl[11] = '{0, 0, 32'hBFC00400, 4'hF, 32'h0,        32'h0,        1, 1};
        tbl[12] = '{0, 0, 32'hBFC00000, 4'hF, 32'h0,        32'h24040020, 1, 1};

        rst_n = 1'b0; sel = 1'b0; address = '0; writedata = '0; byteenable = '0;
        read = 1'b0; write = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wq_a", 32'(wq_a), 32'd0);
        check("reset_wq_b", 32'(wq_b), 32'd0);
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_rd_b", rd_b, 32'h0);
        check("reset_re_a", 32'(re_a), 32'd0);
        check("reset_re_b", 32'(re_b), 32'd0);

        // Preload while the block is still held in reset.
        preload(8'd0, 32'h24040020);
        preload(8'd1, 32'hCAFE0001);
        preload(8'd2, 32'h11223344);
        preload(8'd3, 32'h33333333);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            bus_xfer(tbl[i].s, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].d, 0, 8'd0, 32'h0, rd, st, re);
            check($sformatf("vec%0d_stalls", i), 32'(st), tbl[i].s ? 32'd1 : 32'd3);
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_rerr", i), 32'(re), 32'(tbl[i].exp_re));
        end

        // Reset during WAIT of a write: outputs clear at once, word 3 untouched.
        sel = 1'b0; address = 32'hBFC0000C; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst_async_wq", 32'(waitreq), 32'd0);
        check("rst_async_rd", rdata, 32'h0);
        check("rst_async_rerr", 32'(rerr), 32'd0);
        @(posedge clk); #1;
        write = 1'b0; rst_n = 1'b1;
        bus_xfer(0, 0, 32'hBFC0000C, 4'hF, 32'h0, 0, 8'd0, 32'h0, rd, st, re);
        check("rst_word3_kept", rd, 32'h33333333);

        // Request held across reset restarts a full wait sequence.
        address = 32'hBFC0000C; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_xfer(0, 1, 32'hBFC0000C, 4'hF, 32'hDEADBEEF, 0, 8'd0, 32'h0, rd, st, re);
        check("rst_held_stalls", 32'(st), 32'd3);
        bus_xfer(0, 0, 32'hBFC0000C, 4'hF, 32'h0, 0, 8'd0, 32'h0, rd, st, re);
        check("rst_held_word3", rd, 32'hDEADBEEF);

        // Preload collides with a completing bus write to the same word.
        bus_xfer(0, 1, 32'hBFC00014, 4'hF, 32'h1, 1, 8'd5, 32'h2, rd, st, re);
        bus_xfer(0, 0, 32'hBFC00014, 4'hF, 32'h0, 0, 8'd0, 32'h0, rd, st, re);
        check("collide_preload_wins", rd, 32'h2);

        // Randomized phase against a word-array model of both instances.
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            preload(8'(i), d);
            model[0][i] = d;
            model[1][i] = d;
        end
        model_rerr[0] = 0;
        model_rerr[1] = 0;
        for (int n = 0; n < 300; n++) begin
            s  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'hBFC00000 + 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
            be = 4'($urandom_range(0, 15));
            d  = $urandom;
            pl = ($urandom_range(0, 4) == 0);
            pa = ($urandom_range(0, 1) == 0) ? word_of(a) : 8'($urandom_range(0, 255));
            pd = $urandom;
            inr = in_rng(a);
            w   = word_of(a);
            exp_rd = inr ? model[s][w] : 32'h0;
            bus_xfer(s, wr, a, be, d, pl, pa, pd, rd, st, re);
            if (wr && inr)
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[s][w][8*b +: 8] = d[8*b +: 8];
            if (!inr) model_rerr[s] = 1;
            if (pl) begin
                model[0][pa] = pd;
                model[1][pa] = pd;
            end
            check($sformatf("rnd%0d_stalls", n), 32'(st), s ? 32'd1 : 32'd3);
            if (!wr) check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            check($sformatf("rnd%0d_rerr", n), 32'(re), 32'(model_rerr[s]));
        end

        // Final sweep of a few words in each instance.
        for (int i = 0; i < 16; i++) begin
            s = 1'(i & 1);
            w = 8'($urandom_range(0, 255));
            bus_xfer(s, 0, 32'hBFC00000 + 32'(w) * 4, 4'hF, 32'h0, 0, 8'd0, 32'h0, rd, st, re);
            check($sformatf("sweep%0d", i), rd, model[s][w]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
